// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared constants for the EX-stage hazard and forwarding control slice.
package hazard_forward_ctrl_pkg;

  // Operand mux select encodings; 2'd3 is never driven.
  localparam logic [1:0] FWD_REGFILE = 2'd0;
  localparam logic [1:0] FWD_WB      = 2'd1;
  localparam logic [1:0] FWD_MEM     = 2'd2;

  // Hard-wired zero register: never a forwarding or stall source.
  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// ID-stage hazard inputs and pipeline control outputs of the hazard/forward controller.
interface hazard_forward_ctrl_if #(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
);

  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic [REG_W-1:0] id_dest;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             ex_branch_tkn;

  logic [1:0]       fwd_a_sel;
  logic [1:0]       fwd_b_sel;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             ifid_flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: presents the ID instruction and branch outcome, consumes controls.
  modport master (
    output id_rs, id_rt, id_dest, id_reg_write, id_mem_read, ex_branch_tkn,
    input  fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble, ifid_flush,
    input  stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_dest, id_reg_write, id_mem_read, ex_branch_tkn,
    output fwd_a_sel, fwd_b_sel, pc_write, ifid_write, idex_bubble, ifid_flush,
    output stall_cnt, flush_cnt
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_sel_unit.sv
// Forward select for one ALU operand: MEM result beats WB result beats register file.
module fwd_sel_unit
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] ex_src_i,
  input  logic [REG_W-1:0] mem_dest_i,
  input  logic             mem_rw_i,
  input  logic [REG_W-1:0] wb_dest_i,
  input  logic             wb_rw_i,
  output logic [1:0]       sel_o
);

  localparam logic [REG_W-1:0] Zero = REG_W'(REG_ZERO);

  // Priority compare of the EX source against the younger MEM and older WB writers.
  always_comb begin
    sel_o = FWD_REGFILE;
    if (mem_rw_i && (mem_dest_i != Zero) && (mem_dest_i == ex_src_i)) begin
      sel_o = FWD_MEM;
    end else if (wb_rw_i && (wb_dest_i != Zero) && (wb_dest_i == ex_src_i)) begin
      sel_o = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// EX-stage forwarding, load-use stall and taken-branch flush control for the 5-stage core.
// Tracks dest/RegWrite/MemRead of the instructions in EX, MEM and WB on its own.
module hazard_forward_ctrl
  import hazard_forward_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  hazard_forward_ctrl_if.slave bus
);

  localparam logic [REG_W-1:0] Zero = REG_W'(REG_ZERO);

  logic [REG_W-1:0] ex_rs_q, ex_rt_q, ex_dest_q;
  logic             ex_rw_q, ex_mr_q;
  logic [REG_W-1:0] mem_dest_q, wb_dest_q;
  logic             mem_rw_q, wb_rw_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use;
  logic stall;
  logic flush;
  logic bubble;

  // Hazard detection; a taken branch squashes the stalled instruction anyway, so it wins.
  always_comb begin
    load_use = ex_mr_q && (ex_dest_q != Zero) &&
               ((ex_dest_q == bus.id_rs) || (ex_dest_q == bus.id_rt));
    flush    = bus.ex_branch_tkn;
    stall    = load_use && !flush;
    bubble   = stall || flush;
  end

  // Pipeline register controls, zero latency from state and ID inputs.
  always_comb begin
    bus.pc_write    = !stall;
    bus.ifid_write  = !stall;
    bus.idex_bubble = bubble;
    bus.ifid_flush  = flush;
    bus.stall_cnt   = stall_cnt_q;
    bus.flush_cnt   = flush_cnt_q;
  end

  fwd_sel_unit #(
    .REG_W (REG_W)
  ) u_fwd_a (
    .ex_src_i   (ex_rs_q),
    .mem_dest_i (mem_dest_q),
    .mem_rw_i   (mem_rw_q),
    .wb_dest_i  (wb_dest_q),
    .wb_rw_i    (wb_rw_q),
    .sel_o      (bus.fwd_a_sel)
  );

  fwd_sel_unit #(
    .REG_W (REG_W)
  ) u_fwd_b (
    .ex_src_i   (ex_rt_q),
    .mem_dest_i (mem_dest_q),
    .mem_rw_i   (mem_rw_q),
    .wb_dest_i  (wb_dest_q),
    .wb_rw_i    (wb_rw_q),
    .sel_o      (bus.fwd_b_sel)
  );

  // Saturating event counters.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // Scoreboard advance ID->EX->MEM->WB; a bubble enters EX as an instruction with no effects.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_rs_q     <= '0;
      ex_rt_q     <= '0;
      ex_dest_q   <= '0;
      ex_rw_q     <= 1'b0;
      ex_mr_q     <= 1'b0;
      mem_dest_q  <= '0;
      mem_rw_q    <= 1'b0;
      wb_dest_q   <= '0;
      wb_rw_q     <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bubble) begin
        ex_rs_q   <= '0;
        ex_rt_q   <= '0;
        ex_dest_q <= '0;
        ex_rw_q   <= 1'b0;
        ex_mr_q   <= 1'b0;
      end else begin
        ex_rs_q   <= bus.id_rs;
        ex_rt_q   <= bus.id_rt;
        ex_dest_q <= bus.id_dest;
        ex_rw_q   <= bus.id_reg_write;
        ex_mr_q   <= bus.id_mem_read;
      end
      mem_dest_q  <= ex_dest_q;
      mem_rw_q    <= ex_rw_q;
      wb_dest_q   <= mem_dest_q;
      wb_rw_q     <= mem_rw_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed scoreboard bench: the driver queues hand-computed expectations per cycle,
// the monitor pops and compares on the falling edge. A 4-bit-counter twin sees the same
// stimulus so stall/flush saturation is reachable in few cycles.
module tb_hazard_forward_ctrl;

  localparam logic [3:0] CtlRun   = 4'b1100; // {pc_write, ifid_write, idex_bubble, ifid_flush}
  localparam logic [3:0] CtlStall = 4'b0010;
  localparam logic [3:0] CtlFlush = 4'b1111;

  logic clk;
  logic rst;

  hazard_forward_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();
  hazard_forward_ctrl_if #(.REG_W(5), .CNT_W(4))  sbus ();

  assign sbus.id_rs         = bus.id_rs;
  assign sbus.id_rt         = bus.id_rt;
  assign sbus.id_dest       = bus.id_dest;
  assign sbus.id_reg_write  = bus.id_reg_write;
  assign sbus.id_mem_read   = bus.id_mem_read;
  assign sbus.ex_branch_tkn = bus.ex_branch_tkn;

  hazard_forward_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  hazard_forward_ctrl #(.REG_W(5), .CNT_W(4)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          chk;
    logic [47:0] exp;
  } rec_t;

  rec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'hF : v[3:0];
  endfunction

  // Apply one cycle of ID inputs and queue what the controllers must show in that cycle.
  task automatic step(input string nm, input bit chk,
                      input int rs, input int rt, input int dest,
                      input bit rw, input bit mr, input bit br, input bit r,
                      input logic [1:0] fa, input logic [1:0] fb, input logic [3:0] ctl,
                      input int sc, input int fc);
    rec_t rec;
    @(posedge clk);
    #1;
    rst               = r;
    bus.id_rs         = rs[4:0];
    bus.id_rt         = rt[4:0];
    bus.id_dest       = dest[4:0];
    bus.id_reg_write  = rw;
    bus.id_mem_read   = mr;
    bus.ex_branch_tkn = br;
    rec.nm  = nm;
    rec.chk = chk;
    rec.exp = {fa, fb, ctl, sc[15:0], fc[15:0], sat4(sc), sat4(fc)};
    sb_q.push_back(rec);
  endtask

  task automatic nop(input string nm, input bit chk, input logic [1:0] fa, input logic [1:0] fb,
                     input int sc, input int fc);
    step(nm, chk, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb, CtlRun, sc, fc);
  endtask

  // Monitor: one queued expectation per cycle, sampled mid-cycle.
  initial begin
    rec_t        r;
    logic [47:0] act;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        r   = sb_q.pop_front();
        act = {bus.fwd_a_sel, bus.fwd_b_sel, bus.pc_write, bus.ifid_write, bus.idex_bubble,
               bus.ifid_flush, bus.stall_cnt, bus.flush_cnt, sbus.stall_cnt, sbus.flush_cnt};
        if (r.chk) begin
          checks++;
          if (act !== r.exp) begin
            errors++;
            $display("FAIL %s: got fa=%0d fb=%0d ctl=%b sc=%h fc=%h ssc=%h sfc=%h, want fa=%0d fb=%0d ctl=%b sc=%h fc=%h ssc=%h sfc=%h",
                     r.nm, act[47:46], act[45:44], act[43:40], act[39:24], act[23:8],
                     act[7:4], act[3:0], r.exp[47:46], r.exp[45:44], r.exp[43:40],
                     r.exp[39:24], r.exp[23:8], r.exp[7:4], r.exp[3:0]);
          end
        end
      end
    end
  end

  initial begin
    rst               = 1'b1;
    bus.id_rs         = '0;
    bus.id_rt         = '0;
    bus.id_dest       = '0;
    bus.id_reg_write  = 1'b0;
    bus.id_mem_read   = 1'b0;
    bus.ex_branch_tkn = 1'b0;
    step("rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CtlRun, 0, 0);
    step("rst", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, CtlRun, 0, 0);
    nop("reset_state", 1, 0, 0, 0, 0);

    // 1: add $3 ; add $4,$3,$5 -> rs forwarded from MEM.
    step("t1_issue3", 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    step("t1_issue4", 1, 3, 5, 4, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    nop("t1_mem_fwd_a", 1, 2, 0, 0, 0);

    // 2: $3 two back on rt -> WB; then $3 in both MEM and WB -> MEM wins.
    step("t2_issue3", 1, 1, 2, 3, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    step("t2_issue6", 0, 7, 8, 6, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    step("t2_issue9", 0, 10, 3, 9, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    nop("t2_wb_fwd_b", 1, 0, 1, 0, 0);
    step("t2_issue3a", 0, 1, 2, 3, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    step("t2_issue3b", 0, 1, 2, 3, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    step("t2_issue11", 0, 3, 3, 11, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    nop("t2_mem_beats_wb", 1, 2, 2, 0, 0);

    // 3: lw $5 ; add $12,$5,$2 -> one stall, then WB forward.
    step("t3_issue_lw", 1, 1, 5, 5, 1, 1, 0, 0, 0, 0, CtlRun, 0, 0);
    step("t3_stall", 1, 5, 2, 12, 1, 0, 0, 0, 0, 0, CtlStall, 0, 0);
    step("t3_replay", 1, 5, 2, 12, 1, 0, 0, 0, 0, 0, CtlRun, 1, 0);
    nop("t3_wb_fwd_a", 1, 1, 0, 1, 0);

    // 4: taken branch with a load-use hazard in the same cycle.
    step("t4_issue_lw", 0, 1, 7, 7, 1, 1, 0, 0, 0, 0, CtlRun, 1, 0);
    step("t4_branch_wins", 1, 7, 1, 13, 1, 0, 1, 0, 0, 0, CtlFlush, 1, 0);
    nop("t4_counts", 1, 0, 0, 1, 1);

    // 5: writes and loads to $0 never forward or stall.
    step("t5_add0", 0, 1, 2, 0, 1, 0, 0, 0, 0, 0, CtlRun, 1, 1);
    step("t5_lw0", 0, 1, 0, 0, 1, 1, 0, 0, 0, 0, CtlRun, 1, 1);
    step("t5_lw0_no_stall", 1, 0, 0, 14, 1, 0, 0, 0, 0, 0, CtlRun, 1, 1);
    nop("t5_zero_no_fwd", 1, 0, 0, 1, 1);

    // 6: reset during a stall (hazard via rt).
    step("t6_issue_lw", 0, 1, 5, 5, 1, 1, 0, 0, 0, 0, CtlRun, 1, 1);
    step("t6_stall_rt", 1, 2, 5, 12, 1, 0, 0, 1, 0, 0, CtlStall, 1, 1);
    step("t6_after_rst", 1, 2, 5, 12, 1, 0, 0, 0, 0, 0, CtlRun, 0, 0);
    nop("t6_no_stale_fwd", 1, 0, 0, 0, 0);

    // Saturation: 20 stalls (4-bit twin pins at 15), then enough flushes to pin 16 bits.
    for (int i = 0; i < 20; i++) begin
      step("sat_lw", 0, 1, 5, 5, 1, 1, 0, 0, 0, 0, CtlRun, i, 0);
      step("sat_stall", 1, 5, 2, 12, 1, 0, 0, 0, 0, 0, CtlStall, i, 0);
      step("sat_replay", 0, 5, 2, 12, 1, 0, 0, 0, 0, 0, CtlRun, i + 1, 0);
    end
    for (int i = 0; i < 3; i++) nop("sat_drain", 0, 0, 0, 20, 0);
    for (int k = 0; k < 65540; k++) begin
      step("sat_flush", (k < 2) || (k >= 65533), 0, 0, 0, 0, 0, 1, 0, 0, 0, CtlFlush,
           20, (k > 65535) ? 65535 : k);
    end
    nop("sat_flush_held", 1, 0, 0, 20, 65535);
    step("sat_lw_end", 0, 1, 5, 5, 1, 1, 0, 0, 0, 0, CtlRun, 20, 65535);
    step("sat_stall_end", 1, 5, 2, 12, 1, 0, 0, 0, 0, 0, CtlStall, 20, 65535);
    step("sat_final", 1, 5, 2, 12, 1, 0, 0, 0, 0, 0, CtlRun, 21, 65535);

    repeat (3) @(posedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
